// File: rtl/ysyx_22040632_exec_sequencer.sv
// Multi-cycle NPC control sequencer: fetch, decode, execute, optional memory access, write-back.
// Owns the architectural PC, the retired-instruction counter and the halt condition.
module ysyx_22040632_exec_sequencer #(
  parameter logic [63:0] ResetPc = 64'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  output logic        ifu_req_valid_o,
  output logic [63:0] ifu_req_addr_o,
  input  logic        ifu_req_ready_i,
  input  logic        ifu_rsp_valid_i,
  input  logic [31:0] ifu_rsp_data_i,
  output logic [31:0] instr_o,
  input  logic [2:0]  dec_class_i,
  input  logic        dec_rf_we_i,
  input  logic [63:0] exu_next_pc_i,
  input  logic        exu_taken_i,
  output logic        lsu_req_valid_o,
  input  logic        lsu_req_ready_i,
  input  logic        lsu_rsp_valid_i,
  output logic        rf_we_o,
  output logic [63:0] pc_o,
  output logic        retire_o,
  output logic [63:0] instr_cnt_o,
  output logic        halted_o,
  output logic [1:0]  halt_cause_o
);

  localparam logic [2:0]  ClsLoad       = 3'd1;
  localparam logic [2:0]  ClsStore      = 3'd2;
  localparam logic [2:0]  ClsEbreak     = 3'd4;
  localparam logic [1:0]  CauseEbreak   = 2'd1;
  localparam logic [1:0]  CauseIllegal  = 2'd2;
  localparam logic [1:0]  CauseMisalign = 2'd3;
  localparam logic [31:0] InstrNop      = 32'h0000_0013;

  typedef enum logic [3:0] {
    StIdle, StFetchReq, StFetchRsp, StDecode, StExec, StMemReq, StMemRsp, StWb, StHalt
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [63:0] cnt_q, cnt_d;
  logic [2:0]  cls_q, cls_d;
  logic        we_q, we_d;
  logic [63:0] npc_q, npc_d;
  logic [1:0]  cause_q, cause_d;
  logic        ebreak_ret_q, ebreak_ret_d;

  logic [63:0] exec_npc;
  logic        dec_illegal;
  logic        cls_is_mem;

  assign exec_npc    = exu_taken_i ? exu_next_pc_i : pc_q + 64'd4;
  assign dec_illegal = dec_class_i > ClsEbreak;
  assign cls_is_mem  = (cls_q == ClsLoad) || (cls_q == ClsStore);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (start_i) state_d = StFetchReq;
      StFetchReq: if (ifu_req_ready_i) state_d = StFetchRsp;
      StFetchRsp: if (ifu_rsp_valid_i) state_d = StDecode;
      StDecode:   state_d = (dec_class_i == ClsEbreak || dec_illegal) ? StHalt : StExec;
      StExec: begin
        if (exec_npc[1:0] != 2'b00) state_d = StHalt;
        else if (cls_is_mem)        state_d = StMemReq;
        else                        state_d = StWb;
      end
      StMemReq:   if (lsu_req_ready_i) state_d = StMemRsp;
      StMemRsp:   if (lsu_rsp_valid_i) state_d = StWb;
      StWb:       state_d = StFetchReq;
      StHalt:     state_d = StHalt;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    pc_d         = pc_q;
    instr_d      = instr_q;
    cnt_d        = cnt_q;
    cls_d        = cls_q;
    we_d         = we_q;
    npc_d        = npc_q;
    cause_d      = cause_q;
    ebreak_ret_d = 1'b0;
    unique case (state_q)
      StFetchRsp: if (ifu_rsp_valid_i) instr_d = ifu_rsp_data_i;
      StDecode: begin
        cls_d = dec_class_i;
        we_d  = dec_rf_we_i;
        // ebreak retires itself on the way into HALT; pc stays at the ebreak
        if (dec_class_i == ClsEbreak) begin
          cause_d      = CauseEbreak;
          cnt_d        = cnt_q + 64'd1;
          ebreak_ret_d = 1'b1;
        end else if (dec_illegal) begin
          cause_d = CauseIllegal;
        end
      end
      StExec: begin
        npc_d = exec_npc;
        if (exec_npc[1:0] != 2'b00) cause_d = CauseMisalign;
      end
      StWb: begin
        pc_d  = npc_q;
        cnt_d = cnt_q + 64'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q         <= ResetPc;
      instr_q      <= InstrNop;
      cnt_q        <= 64'd0;
      cls_q        <= 3'd0;
      we_q         <= 1'b0;
      npc_q        <= ResetPc;
      cause_q      <= 2'd0;
      ebreak_ret_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      cnt_q        <= cnt_d;
      cls_q        <= cls_d;
      we_q         <= we_d;
      npc_q        <= npc_d;
      cause_q      <= cause_d;
      ebreak_ret_q <= ebreak_ret_d;
    end
  end

  // Outputs depend on state and registers only.
  always_comb begin
    ifu_req_valid_o = (state_q == StFetchReq);
    ifu_req_addr_o  = pc_q;
    lsu_req_valid_o = (state_q == StMemReq);
    rf_we_o         = (state_q == StWb) && we_q && (cls_q != ClsStore);
    retire_o        = (state_q == StWb) || ebreak_ret_q;
    halted_o        = (state_q == StHalt);
    halt_cause_o    = cause_q;
    pc_o            = pc_q;
    instr_o         = instr_q;
    instr_cnt_o     = cnt_q;
  end

endmodule

// File: tb/tb_ysyx_22040632_exec_sequencer.sv
// Bench for the exec sequencer: a reactive memory/decoder stub plus a per-cycle expectation
// timeline computed from the program table and instruction timing rules.
module tb_ysyx_22040632_exec_sequencer;

  localparam logic [63:0] ResetPc = 64'h8000_0000;
  localparam logic [31:0] Nop     = 32'h0000_0013;
  localparam int          MaxCyc  = 1024;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        ifu_req_valid_o;
  logic [63:0] ifu_req_addr_o;
  logic        ifu_req_ready_i = 1'b0;
  logic        ifu_rsp_valid_i = 1'b0;
  logic [31:0] ifu_rsp_data_i = 32'h0;
  logic [31:0] instr_o;
  logic [2:0]  dec_class_i;
  logic        dec_rf_we_i;
  logic [63:0] exu_next_pc_i;
  logic        exu_taken_i;
  logic        lsu_req_valid_o;
  logic        lsu_req_ready_i = 1'b0;
  logic        lsu_rsp_valid_i = 1'b0;
  logic        rf_we_o;
  logic [63:0] pc_o;
  logic        retire_o;
  logic [63:0] instr_cnt_o;
  logic        halted_o;
  logic [1:0]  halt_cause_o;

  ysyx_22040632_exec_sequencer #(.ResetPc(ResetPc)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .ifu_req_valid_o(ifu_req_valid_o), .ifu_req_addr_o(ifu_req_addr_o),
    .ifu_req_ready_i(ifu_req_ready_i), .ifu_rsp_valid_i(ifu_rsp_valid_i),
    .ifu_rsp_data_i(ifu_rsp_data_i), .instr_o(instr_o),
    .dec_class_i(dec_class_i), .dec_rf_we_i(dec_rf_we_i),
    .exu_next_pc_i(exu_next_pc_i), .exu_taken_i(exu_taken_i),
    .lsu_req_valid_o(lsu_req_valid_o), .lsu_req_ready_i(lsu_req_ready_i),
    .lsu_rsp_valid_i(lsu_rsp_valid_i), .rf_we_o(rf_we_o), .pc_o(pc_o),
    .retire_o(retire_o), .instr_cnt_o(instr_cnt_o), .halted_o(halted_o),
    .halt_cause_o(halt_cause_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Program: class, rd write, taken/target, fetch ready/rsp waits, lsu ready/rsp waits.
  typedef struct {
    int          cls;
    bit          we;
    bit          taken;
    logic [63:0] tgt;
    int          wr;
    int          wrsp;
    int          lw;
    int          lrw;
  } ins_t;
  ins_t prog[8];
  int   prog_n = 0;

  function automatic void add(int cls, bit we, bit taken, logic [63:0] tgt,
                              int wr, int wrsp, int lw, int lrw);
    prog[prog_n] = '{cls, we, taken, tgt, wr, wrsp, lw, lrw};
    prog_n++;
  endfunction

  // Decoder/ALU stub: fetched words carry the program index in their low byte.
  int dec_idx;
  always_comb begin
    dec_idx       = -1;
    dec_class_i   = 3'd0;
    dec_rf_we_i   = 1'b0;
    exu_taken_i   = 1'b0;
    exu_next_pc_i = 64'h0;
    if (instr_o[31:16] == 16'hA5A5 && int'(instr_o[7:0]) < prog_n) dec_idx = int'(instr_o[7:0]);
    if (dec_idx >= 0) begin
      dec_class_i   = 3'(prog[dec_idx].cls);
      dec_rf_we_i   = prog[dec_idx].we;
      exu_taken_i   = prog[dec_idx].taken;
      exu_next_pc_i = prog[dec_idx].tgt;
    end
  end

  // Expected per-cycle outputs.
  bit          e_req[MaxCyc];
  bit          e_lsu[MaxCyc];
  bit          e_ret[MaxCyc];
  bit          e_rfwe[MaxCyc];
  logic [63:0] e_pc[MaxCyc];
  logic [63:0] e_cnt[MaxCyc];
  bit          e_halt[MaxCyc];
  logic [1:0]  e_cause[MaxCyc];

  function automatic void steady(int from, logic [63:0] pc, logic [63:0] cnt, bit h,
                                 logic [1:0] c);
    for (int k = from; k < MaxCyc; k++) begin
      e_req[k] = 0; e_lsu[k] = 0; e_ret[k] = 0; e_rfwe[k] = 0;
      e_pc[k] = pc; e_cnt[k] = cnt; e_halt[k] = h; e_cause[k] = c;
    end
  endfunction

  // Timeline: each phase lasts 1 cycle plus its wait count; s is the IDLE cycle with start high.
  function automatic void plan(int s);
    int          t = s;
    logic [63:0] pc = ResetPc;
    logic [63:0] cnt = 64'd0;
    logic [63:0] npc;
    steady(s, pc, cnt, 0, 2'd0);
    for (int i = 0; i < prog_n; i++) begin
      for (int k = 0; k <= prog[i].wr; k++) e_req[t + 1 + k] = 1;
      t += 1 + prog[i].wr;
      t += 1 + prog[i].wrsp;
      t += 1;
      if (prog[i].cls == 4) begin
        steady(t + 1, pc, cnt + 64'd1, 1, 2'd1);
        e_ret[t + 1] = 1;
        return;
      end
      if (prog[i].cls > 4) begin
        steady(t + 1, pc, cnt, 1, 2'd2);
        return;
      end
      t += 1;
      npc = prog[i].taken ? prog[i].tgt : pc + 64'd4;
      if (npc[1:0] != 2'b00) begin
        steady(t + 1, pc, cnt, 1, 2'd3);
        return;
      end
      if (prog[i].cls == 1 || prog[i].cls == 2) begin
        for (int k = 0; k <= prog[i].lw; k++) e_lsu[t + 1 + k] = 1;
        t += 1 + prog[i].lw;
        t += 1 + prog[i].lrw;
      end
      t += 1;
      e_ret[t]  = 1;
      e_rfwe[t] = prog[i].we && prog[i].cls != 2;
      pc  = npc;
      cnt = cnt + 64'd1;
      steady(t + 1, pc, cnt, 0, 2'd0);
    end
  endfunction

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, exp);
    end
  endtask

  task automatic timeout_fail(string what);
    n_chk++;
    n_fail++;
    $display("FAIL %s at cycle %0d: no request within 40 cycles, required one", what, cyc);
  endtask

  int   start_cyc = 0;
  int   ret_q[$];
  logic [63:0] addr_q[$];
  int   n_rfwe = 0;
  int   n_lsu = 0;

  always @(negedge clk_i) begin
    if (cyc < MaxCyc) begin
      check("ifu_req_valid", ifu_req_valid_o, e_req[cyc]);
      if (e_req[cyc]) check("ifu_req_addr", ifu_req_addr_o, e_pc[cyc]);
      check("lsu_req_valid", lsu_req_valid_o, e_lsu[cyc]);
      check("retire", retire_o, e_ret[cyc]);
      check("rf_we", rf_we_o, e_rfwe[cyc]);
      check("pc", pc_o, e_pc[cyc]);
      check("instr_cnt", instr_cnt_o, e_cnt[cyc]);
      check("halted", halted_o, e_halt[cyc]);
      check("halt_cause", halt_cause_o, e_cause[cyc]);
      if (retire_o) ret_q.push_back(cyc - start_cyc);
      if (rf_we_o) n_rfwe++;
      if (lsu_req_valid_o) n_lsu++;
      if (ifu_req_valid_o && ifu_req_ready_i) addr_q.push_back(ifu_req_addr_o);
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    start_i = 1'b0;
    ifu_req_ready_i = 1'b0;
    ifu_rsp_valid_i = 1'b0;
    lsu_req_ready_i = 1'b0;
    lsu_rsp_valid_i = 1'b0;
    steady(cyc, ResetPc, 64'd0, 0, 2'd0);
    repeat (2) step();
    rst_ni = 1'b1;
    step();
  endtask

  // Serves the program; returns after a halting decode or after abort_rsp MEM_RSP wait cycles.
  task automatic run_prog(int abort_rsp);
    int k;
    ret_q.delete();
    addr_q.delete();
    n_rfwe = 0;
    n_lsu = 0;
    start_cyc = cyc;
    plan(cyc);
    start_i = 1'b1;
    for (int i = 0; i < prog_n; i++) begin
      k = 0;
      while (!ifu_req_valid_o) begin
        step();
        k++;
        if (k > 40) begin
          timeout_fail("ifu_req_wait");
          return;
        end
      end
      repeat (prog[i].wr) step();
      ifu_req_ready_i = 1'b1;
      step();
      ifu_req_ready_i = 1'b0;
      // a stray lsu response while the fetch is outstanding must be ignored
      lsu_rsp_valid_i = (prog[i].wrsp > 0);
      repeat (prog[i].wrsp) step();
      lsu_rsp_valid_i = 1'b0;
      ifu_rsp_valid_i = 1'b1;
      ifu_rsp_data_i  = 32'hA5A5_0000 | 32'(i);
      step();
      ifu_rsp_valid_i = 1'b0;
      if (prog[i].cls >= 4) return;
      if (prog[i].taken && prog[i].tgt[1:0] != 2'b00) return;
      if (prog[i].cls == 1 || prog[i].cls == 2) begin
        k = 0;
        while (!lsu_req_valid_o) begin
          step();
          k++;
          if (k > 40) begin
            timeout_fail("lsu_req_wait");
            return;
          end
        end
        repeat (prog[i].lw) step();
        lsu_req_ready_i = 1'b1;
        step();
        lsu_req_ready_i = 1'b0;
        ifu_rsp_valid_i = 1'b1;
        for (int r = 0; r < prog[i].lrw; r++) begin
          if (r == abort_rsp) return;
          step();
        end
        ifu_rsp_valid_i = 1'b0;
        lsu_rsp_valid_i = 1'b1;
        step();
        lsu_rsp_valid_i = 1'b0;
      end
    end
  endtask

  initial begin
    steady(0, ResetPc, 64'd0, 0, 2'd0);
    repeat (2) step();
    rst_ni = 1'b1;
    step();
    check("reset_instr", instr_o, Nop);
    check("reset_pc", pc_o, 64'h8000_0000);

    // Three ALU instructions, then an illegal one.
    prog_n = 0;
    add(0, 1, 0, 0, 0, 0, 0, 0); add(0, 1, 0, 0, 0, 0, 0, 0); add(0, 1, 0, 0, 0, 0, 0, 0);
    add(7, 1, 0, 0, 0, 0, 0, 0);
    run_prog(-1);
    repeat (6) step();
    check("alu_retires", ret_q.size(), 3);
    if (ret_q.size() == 3) begin
      check("alu_ret0", ret_q[0], 5);
      check("alu_ret1", ret_q[1], 10);
      check("alu_ret2", ret_q[2], 15);
    end
    check("alu_rf_we_pulses", n_rfwe, 3);
    check("alu_pc", pc_o, 64'h8000_000C);
    check("alu_cnt", instr_cnt_o, 64'd3);
    check("illegal_cause", halt_cause_o, 2'd2);

    // Not-taken branch, taken jump, ALU at target, misaligned jump.
    do_reset();
    prog_n = 0;
    add(3, 0, 0, 0, 0, 0, 0, 0);
    add(3, 1, 1, 64'h8000_0100, 2, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(3, 0, 1, 64'h8000_0102, 0, 0, 0, 0);
    run_prog(-1);
    repeat (6) step();
    check("br_fetches", addr_q.size(), 4);
    if (addr_q.size() == 4) check("br_target_fetch", addr_q[2], 64'h8000_0100);
    check("misalign_halted", halted_o, 1);
    check("misalign_cause", halt_cause_o, 2'd3);
    check("misalign_cnt", instr_cnt_o, 64'd3);
    check("misalign_pc", pc_o, 64'h8000_0104);

    // Stalled store, stalled load, ebreak.
    do_reset();
    prog_n = 0;
    add(2, 1, 0, 0, 0, 0, 3, 2);
    add(1, 1, 0, 0, 1, 2, 0, 0);
    add(4, 0, 0, 0, 0, 0, 0, 0);
    run_prog(-1);
    repeat (6) step();
    check("mem_retires", ret_q.size(), 3);
    if (ret_q.size() == 3) begin
      check("store_ret", ret_q[0], 12);
      check("load_ret", ret_q[1], 22);
      check("ebreak_ret", ret_q[2], 26);
    end
    check("mem_lsu_cycles", n_lsu, 5);
    check("mem_rf_we_pulses", n_rfwe, 1);
    check("mem_cnt", instr_cnt_o, 64'd3);

    // Two ALU then ebreak; halted core ignores further stimulus.
    do_reset();
    prog_n = 0;
    add(0, 1, 0, 0, 0, 0, 0, 0); add(0, 0, 0, 0, 0, 0, 0, 0);
    add(4, 0, 0, 0, 0, 0, 0, 0);
    run_prog(-1);
    repeat (3) step();
    ifu_req_ready_i = 1'b1;
    ifu_rsp_valid_i = 1'b1;
    ifu_rsp_data_i  = 32'hDEAD_BEEF;
    lsu_req_ready_i = 1'b1;
    lsu_rsp_valid_i = 1'b1;
    repeat (5) step();
    ifu_req_ready_i = 1'b0;
    ifu_rsp_valid_i = 1'b0;
    lsu_req_ready_i = 1'b0;
    lsu_rsp_valid_i = 1'b0;
    check("ebreak_ret_cycle", (ret_q.size() == 3) ? ret_q[2] : -1, 14);
    check("ebreak_instr_held", instr_o, 32'hA5A5_0002);
    check("ebreak_cnt", instr_cnt_o, 64'd3);
    check("ebreak_pc", pc_o, 64'h8000_0008);
    check("ebreak_cause", halt_cause_o, 2'd1);

    // Reset during MEM_RSP, stray response in IDLE, then restart.
    do_reset();
    prog_n = 0;
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 8);
    run_prog(3);
    do_reset();
    check("rst_instr", instr_o, Nop);
    check("rst_cnt", instr_cnt_o, 64'd0);
    lsu_rsp_valid_i = 1'b1;
    repeat (2) step();
    lsu_rsp_valid_i = 1'b0;
    step();
    prog_n = 0;
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(4, 0, 0, 0, 0, 0, 0, 0);
    run_prog(-1);
    repeat (4) step();
    check("restart_first_fetch", (addr_q.size() > 0) ? addr_q[0] : 64'h0, 64'h8000_0000);
    check("restart_cnt", instr_cnt_o, 64'd2);
    check("restart_pc", pc_o, 64'h8000_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
